// File: rtl/tc_pkg.sv
// Shared definitions for the FP16 dot-product / Kulisch accumulator slice.
//   FP_* : IEEE binary16 field layout and bias
//   KULISCH_LSB_EXP : weight of accumulator bit 0 (2^-48, smallest subnormal product)
//   lane_flags_t : per-lane special-value flags carried alongside each product
package tc_pkg;

   localparam int FP_DWIDTH       = 16;
   localparam int FP_EWIDTH       = 5;
   localparam int FP_MWIDTH       = 10;
   localparam int FP_BIAS         = 15;
   localparam int KULISCH_LSB_EXP = -48;
   localparam int KULISCH_AWIDTH  = 91;
   localparam int DEF_LANES       = 4;

   typedef struct packed {
      logic nan;
      logic pinf;
      logic ninf;
   } lane_flags_t;

   function automatic lane_flags_t merge_flags(input lane_flags_t x, input lane_flags_t y);
      merge_flags = x | y;
   endfunction

endpackage

// File: rtl/tc_fp16_prod_align.sv
// One lane of the dot-product pipeline: FP16 decode + exact multiply (S1),
// then alignment onto the Kulisch grid and sign application (S2).
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : pipeline advance; both stages hold while low
//   a, b       : FP16 operands
//   prod       : signed AWIDTH product, LSB weight 2^KULISCH_LSB_EXP (S2 register)
//   flags      : NaN / +inf / -inf for this lane's product (S2 register)
module tc_fp16_prod_align
   import tc_pkg::*;
#(
   parameter int DWIDTH = FP_DWIDTH,
   parameter int EWIDTH = FP_EWIDTH,
   parameter int MWIDTH = FP_MWIDTH,
   parameter int BIAS   = FP_BIAS,
   parameter int AWIDTH = KULISCH_AWIDTH
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic [DWIDTH-1:0] a,
   input  logic [DWIDTH-1:0] b,
   output logic [AWIDTH-1:0] prod,
   output lane_flags_t       flags
);

   localparam int SIG_W  = MWIDTH + 1;
   localparam int PROD_W = 2 * SIG_W;
   localparam int XW     = EWIDTH + 1;
   // A significand product weighs 2^(ea+eb-2*BIAS-2*MWIDTH); re-basing to the
   // accumulator LSB turns that into a left shift of (ea+eb-SHIFT_OFF).
   localparam int SHIFT_OFF = 2 * BIAS + 2 * MWIDTH + KULISCH_LSB_EXP;

   // ---------------- S1: decode and multiply ----------------
   logic              a_sign, b_sign;
   logic [EWIDTH-1:0] a_exp, b_exp, a_eff, b_eff;
   logic [MWIDTH-1:0] a_man, b_man;
   logic [SIG_W-1:0]  a_sig, b_sig;
   logic              a_emax, b_emax, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
   logic              lane_nan, lane_inf, prod_sign;
   logic [PROD_W-1:0] sig_prod_next;
   logic [XW-1:0]     exp_sum_next;
   lane_flags_t       s1_flags_next;

   assign a_sign = a[DWIDTH-1];
   assign b_sign = b[DWIDTH-1];
   assign a_exp  = a[MWIDTH +: EWIDTH];
   assign b_exp  = b[MWIDTH +: EWIDTH];
   assign a_man  = a[MWIDTH-1:0];
   assign b_man  = b[MWIDTH-1:0];

   // Subnormals: hidden bit 0, effective exponent 1
   assign a_eff  = (a_exp == '0) ? EWIDTH'(1) : a_exp;
   assign b_eff  = (b_exp == '0) ? EWIDTH'(1) : b_exp;
   assign a_sig  = {(a_exp != '0), a_man};
   assign b_sig  = {(b_exp != '0), b_man};

   assign a_emax = &a_exp;
   assign b_emax = &b_exp;
   assign a_nan  = a_emax && (a_man != '0);
   assign b_nan  = b_emax && (b_man != '0);
   assign a_inf  = a_emax && (a_man == '0);
   assign b_inf  = b_emax && (b_man == '0);
   assign a_zero = (a_exp == '0) && (a_man == '0);
   assign b_zero = (b_exp == '0) && (b_man == '0);

   assign lane_nan  = a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero);
   assign lane_inf  = (a_inf || b_inf) && !lane_nan;
   assign prod_sign = a_sign ^ b_sign;

   // Special operands contribute nothing numerically; only their flags matter.
   assign sig_prod_next = (a_emax || b_emax) ? '0 : PROD_W'(a_sig) * PROD_W'(b_sig);
   assign exp_sum_next  = {1'b0, a_eff} + {1'b0, b_eff};

   assign s1_flags_next.nan  = lane_nan;
   assign s1_flags_next.pinf = lane_inf && !prod_sign;
   assign s1_flags_next.ninf = lane_inf && prod_sign;

   logic              s1_sign_reg;
   logic [PROD_W-1:0] s1_sig_reg;
   logic [XW-1:0]     s1_exp_reg;
   lane_flags_t       s1_flags_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_sign_reg  <= 1'b0;
         s1_sig_reg   <= '0;
         s1_exp_reg   <= '0;
         s1_flags_reg <= '0;
      end else if (en) begin
         s1_sign_reg  <= prod_sign;
         s1_sig_reg   <= sig_prod_next;
         s1_exp_reg   <= exp_sum_next;
         s1_flags_reg <= s1_flags_next;
      end
   end

   // ---------------- S2: align and negate ----------------
   logic [XW-1:0]     s2_shamt;
   logic [AWIDTH-1:0] s2_mag, prod_next;

   // Effective exponents are >= 1, so the shift never goes negative on real data.
   assign s2_shamt  = s1_exp_reg - XW'(SHIFT_OFF);
   assign s2_mag    = AWIDTH'(s1_sig_reg) << s2_shamt;
   assign prod_next = s1_sign_reg ? -s2_mag : s2_mag;

   logic [AWIDTH-1:0] prod_reg;
   lane_flags_t       flags_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prod_reg  <= '0;
         flags_reg <= '0;
      end else if (en) begin
         prod_reg  <= prod_next;
         flags_reg <= s1_flags_reg;
      end
   end

   assign prod  = prod_reg;
   assign flags = flags_reg;

endmodule

// File: rtl/tensor_core_dot_acc.sv
// Streaming FP16 dot-product engine with an exact Kulisch accumulator.
// Each accepted beat multiplies LANES operand pairs exactly and adds every
// product into a wide two's-complement accumulator; groups are framed by
// i_first / i_last and each group's result is presented on a valid/ready port.
//   clk, rst_n               : clock, asynchronous active-low reset
//   i_valid/i_ready          : input beat handshake (i_ready = global advance)
//   i_a, i_b                 : LANES packed FP16 operands (lane 0 in the LSBs)
//   i_first, i_last          : group framing
//   i_init_acc               : accumulator base, used on first beats only
//   o_valid/o_ready          : result handshake
//   o_acc                    : signed Kulisch result, LSB weight 2^-48
//   o_nan, o_inf, o_inf_neg  : group special-value status
//   o_ovf                    : signed accumulator overflow seen in the group
module tensor_core_dot_acc
   import tc_pkg::*;
#(
   parameter int DWIDTH = FP_DWIDTH,
   parameter int EWIDTH = FP_EWIDTH,
   parameter int MWIDTH = FP_MWIDTH,
   parameter int BIAS   = FP_BIAS,
   parameter int LANES  = DEF_LANES,
   parameter int AWIDTH = KULISCH_AWIDTH
)(
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    i_valid,
   output logic                    i_ready,
   input  logic [LANES*DWIDTH-1:0] i_a,
   input  logic [LANES*DWIDTH-1:0] i_b,
   input  logic                    i_first,
   input  logic                    i_last,
   input  logic [AWIDTH-1:0]       i_init_acc,
   output logic                    o_valid,
   input  logic                    o_ready,
   output logic [AWIDTH-1:0]       o_acc,
   output logic                    o_nan,
   output logic                    o_inf,
   output logic                    o_inf_neg,
   output logic                    o_ovf
);

   localparam int LEVELS = $clog2(LANES);
   // Tree is wide enough that summing LANES aligned products never overflows.
   localparam int TREE_W = AWIDTH + LEVELS;

   logic o_valid_reg;
   logic adv;

   // Whole pipeline stalls only when a result is waiting and not being taken.
   assign adv     = !o_valid_reg || o_ready;
   assign i_ready = adv;

   // ---------------- beat control alongside the lane datapath ----------------
   logic              s1_valid_reg, s1_first_reg, s1_last_reg;
   logic              s2_valid_reg, s2_first_reg, s2_last_reg;
   logic [AWIDTH-1:0] s1_init_reg, s2_init_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_valid_reg <= 1'b0;
         s1_first_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s1_init_reg  <= '0;
         s2_valid_reg <= 1'b0;
         s2_first_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s2_init_reg  <= '0;
      end else if (adv) begin
         s1_valid_reg <= i_valid;
         s1_first_reg <= i_first;
         s1_last_reg  <= i_last;
         s1_init_reg  <= i_init_acc;
         s2_valid_reg <= s1_valid_reg;
         s2_first_reg <= s1_first_reg;
         s2_last_reg  <= s1_last_reg;
         s2_init_reg  <= s1_init_reg;
      end
   end

   // ---------------- lanes ----------------
   logic [LANES-1:0] lane_nan, lane_pinf, lane_ninf;

   genvar gi, gl;
   generate
      for (gi = 0; gi < LANES; gi++) begin : g_lane
         logic [AWIDTH-1:0] prod;
         lane_flags_t       flags;

         tc_fp16_prod_align #(
            .DWIDTH (DWIDTH),
            .EWIDTH (EWIDTH),
            .MWIDTH (MWIDTH),
            .BIAS   (BIAS),
            .AWIDTH (AWIDTH)
         ) u_lane (
            .clk   (clk),
            .rst_n (rst_n),
            .en    (adv),
            .a     (i_a[gi*DWIDTH +: DWIDTH]),
            .b     (i_b[gi*DWIDTH +: DWIDTH]),
            .prod  (prod),
            .flags (flags)
         );

         assign lane_nan[gi]  = flags.nan;
         assign lane_pinf[gi] = flags.pinf;
         assign lane_ninf[gi] = flags.ninf;
      end

      // Binary adder tree: level 0 holds sign-extended lane products,
      // each further level halves the node count.
      for (gl = 0; gl <= LEVELS; gl++) begin : g_lvl
         logic [TREE_W-1:0] node [LANES >> gl];
         for (gi = 0; gi < (LANES >> gl); gi++) begin : g_node
            if (gl == 0) begin : g_leaf
               assign node[gi] = {{(TREE_W-AWIDTH){g_lane[gi].prod[AWIDTH-1]}}, g_lane[gi].prod};
            end else begin : g_add
               assign node[gi] = g_lvl[gl-1].node[2*gi] + g_lvl[gl-1].node[2*gi+1];
            end
         end
      end
   endgenerate

   logic [TREE_W-1:0] tree_sum;
   assign tree_sum = g_lvl[LEVELS].node[0];

   // ---------------- S3: accumulate ----------------
   logic [AWIDTH-1:0] acc_reg;
   lane_flags_t       grp_flags_reg;
   logic              grp_ovf_reg;

   logic [AWIDTH-1:0] base_acc, acc_next;
   lane_flags_t       base_flags, beat_flags, grp_flags_next;
   logic              base_ovf, add_ovf, grp_ovf_next;
   logic [TREE_W:0]   sum_ext;
   logic [TREE_W-AWIDTH+1:0] sum_hi;
   logic              nan_out, inf_out, inf_neg_out;

   assign base_acc   = s2_first_reg ? s2_init_reg : acc_reg;
   assign base_flags = s2_first_reg ? lane_flags_t'('0) : grp_flags_reg;
   assign base_ovf   = s2_first_reg ? 1'b0 : grp_ovf_reg;

   assign beat_flags.nan  = |lane_nan;
   assign beat_flags.pinf = |lane_pinf;
   assign beat_flags.ninf = |lane_ninf;

   assign sum_ext = {{(TREE_W+1-AWIDTH){base_acc[AWIDTH-1]}}, base_acc}
                  + {tree_sum[TREE_W-1], tree_sum};

   // The exact sum fits signed AWIDTH only if everything above the AWIDTH-1
   // sign bit is a copy of it; otherwise the stored value wraps.
   assign sum_hi   = sum_ext[TREE_W:AWIDTH-1];
   assign add_ovf  = !((&sum_hi) || !(|sum_hi));
   assign acc_next = sum_ext[AWIDTH-1:0];

   assign grp_flags_next = merge_flags(base_flags, beat_flags);
   assign grp_ovf_next   = base_ovf || add_ovf;

   // Opposite infinities in one group resolve to NaN; NaN masks infinity.
   assign nan_out     = grp_flags_next.nan || (grp_flags_next.pinf && grp_flags_next.ninf);
   assign inf_out     = !nan_out && (grp_flags_next.pinf || grp_flags_next.ninf);
   assign inf_neg_out = inf_out && grp_flags_next.ninf;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc_reg       <= '0;
         grp_flags_reg <= '0;
         grp_ovf_reg   <= 1'b0;
      end else if (adv && s2_valid_reg) begin
         acc_reg       <= acc_next;
         grp_flags_reg <= grp_flags_next;
         grp_ovf_reg   <= grp_ovf_next;
      end
   end

   // ---------------- output register ----------------
   logic [AWIDTH-1:0] o_acc_reg;
   logic              o_nan_reg, o_inf_reg, o_inf_neg_reg, o_ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid_reg   <= 1'b0;
         o_acc_reg     <= '0;
         o_nan_reg     <= 1'b0;
         o_inf_reg     <= 1'b0;
         o_inf_neg_reg <= 1'b0;
         o_ovf_reg     <= 1'b0;
      end else if (adv) begin
         o_valid_reg <= s2_valid_reg && s2_last_reg;
         if (s2_valid_reg && s2_last_reg) begin
            o_acc_reg     <= acc_next;
            o_nan_reg     <= nan_out;
            o_inf_reg     <= inf_out;
            o_inf_neg_reg <= inf_neg_out;
            o_ovf_reg     <= grp_ovf_next;
         end
      end
   end

   assign o_valid   = o_valid_reg;
   assign o_acc     = o_acc_reg;
   assign o_nan     = o_nan_reg;
   assign o_inf     = o_inf_reg;
   assign o_inf_neg = o_inf_neg_reg;
   assign o_ovf     = o_ovf_reg;

endmodule

// File: tb/tb_tensor_core_dot_acc.sv
module tb_tensor_core_dot_acc;

   localparam int LANES = 4;
   localparam int DW    = 16;
   localparam int AW    = 91;
   localparam logic signed [127:0] KMAX = (128'sd1 <<< 90) - 128'sd1;
   localparam logic signed [127:0] KMIN = -(128'sd1 <<< 90);

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   logic                  i_valid = 1'b0;
   logic                  i_ready;
   logic [LANES*DW-1:0]   i_a = '0;
   logic [LANES*DW-1:0]   i_b = '0;
   logic                  i_first = 1'b0;
   logic                  i_last = 1'b0;
   logic [AW-1:0]         i_init_acc = '0;
   logic                  o_valid;
   logic                  o_ready = 1'b1;
   logic [AW-1:0]         o_acc;
   logic                  o_nan, o_inf, o_inf_neg, o_ovf;

   tensor_core_dot_acc dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .i_valid    (i_valid),
      .i_ready    (i_ready),
      .i_a        (i_a),
      .i_b        (i_b),
      .i_first    (i_first),
      .i_last     (i_last),
      .i_init_acc (i_init_acc),
      .o_valid    (o_valid),
      .o_ready    (o_ready),
      .o_acc      (o_acc),
      .o_nan      (o_nan),
      .o_inf      (o_inf),
      .o_inf_neg  (o_inf_neg),
      .o_ovf      (o_ovf)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [AW-1:0] acc;
      logic          nan, inf, neg, ovf, chk_acc;
   } exp_t;

   exp_t exp_q[$];
   int   checks = 0;
   int   failures = 0;
   int   n_results = 0;
   int   rdy_mode = 0;   // 0: always ready, 1: random, 2: held low

   // reference model state (exact integers, units of 2^-48)
   logic signed [127:0] m_acc = '0;
   logic                m_nan = 1'b0, m_pinf = 1'b0, m_ninf = 1'b0, m_ovf = 1'b0;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] want);
      checks++;
      if (got !== want) begin
         failures++;
         $display("FAIL %s got=%h want=%h", tag, got, want);
      end
   endtask

   // FP16 value as an integer multiple of 2^-24
   function automatic logic signed [127:0] fp_units(input logic [15:0] h);
      logic signed [127:0] v;
      int e;
      e = int'(h[14:10]);
      if (e == 0) v = 128'(h[9:0]);
      else        v = (128'(h[9:0]) + 128'sd1024) << (e - 1);
      return h[15] ? -v : v;
   endfunction

   task automatic model_beat(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                             input logic first, input logic last, input logic [AW-1:0] init);
      logic signed [127:0] sum;
      logic [15:0] ha, hb;
      logic an, bn, ai, bi, az, bz;
      exp_t e;
      if (first) begin
         m_acc = {{37{init[AW-1]}}, init};
         m_nan = 0; m_pinf = 0; m_ninf = 0; m_ovf = 0;
      end
      sum = m_acc;
      for (int l = 0; l < LANES; l++) begin
         ha = a[l*DW +: DW];
         hb = b[l*DW +: DW];
         an = (ha[14:10] == 5'h1f) && (ha[9:0] != 0);
         bn = (hb[14:10] == 5'h1f) && (hb[9:0] != 0);
         ai = (ha[14:10] == 5'h1f) && (ha[9:0] == 0);
         bi = (hb[14:10] == 5'h1f) && (hb[9:0] == 0);
         az = (ha[14:0] == 0);
         bz = (hb[14:0] == 0);
         if (an || bn || (ai && bz) || (bi && az)) m_nan = 1;
         else if (ai || bi) begin
            if (ha[15] ^ hb[15]) m_ninf = 1;
            else                 m_pinf = 1;
         end else sum = sum + fp_units(ha) * fp_units(hb);
      end
      if (sum > KMAX || sum < KMIN) m_ovf = 1;
      m_acc = {{37{sum[90]}}, sum[90:0]};
      if (last) begin
         e.acc     = m_acc[AW-1:0];
         e.nan     = m_nan | (m_pinf & m_ninf);
         e.inf     = !e.nan & (m_pinf | m_ninf);
         e.neg     = e.inf & m_ninf;
         e.ovf     = m_ovf;
         e.chk_acc = !(m_nan | m_pinf | m_ninf);
         exp_q.push_back(e);
      end
   endtask

   task automatic send_beat(input logic [LANES*DW-1:0] a, input logic [LANES*DW-1:0] b,
                            input logic first, input logic last, input logic [AW-1:0] init);
      int n;
      n = 0;
      @(negedge clk);
      i_a = a; i_b = b; i_first = first; i_last = last; i_init_acc = init; i_valid = 1'b1;
      while (!i_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      if (!i_ready) begin
         check_eq("iready_timeout", i_ready, 1);
         i_valid = 1'b0;
      end else begin
         model_beat(a, b, first, last, init);
         @(posedge clk);
         #1;
         i_valid = 1'b0;
      end
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk);
         n++;
      end
      if (exp_q.size() != 0) check_eq("drain_timeout", exp_q.size(), 0);
      repeat (2) @(negedge clk);
   endtask

   task automatic check_reset_state();
      check_eq("rst_o_valid", o_valid, 0);
      check_eq("rst_i_ready", i_ready, 1);
      check_eq("rst_o_acc", o_acc, 0);
      check_eq("rst_flags", {o_nan, o_inf, o_inf_neg, o_ovf}, 0);
   endtask

   function automatic logic [LANES*DW-1:0] pack4(input logic [15:0] l0, input logic [15:0] l1,
                                                 input logic [15:0] l2, input logic [15:0] l3);
      return {l3, l2, l1, l0};
   endfunction

   function automatic logic [15:0] rand_fp16();
      int k;
      logic [15:0] h;
      k = $urandom_range(0, 9);
      h[15] = 1'($urandom_range(0, 1));
      if (k == 0)      h[14:0] = '0;
      else if (k == 1) h[14:0] = {5'd0, 10'($urandom)};
      else             h[14:0] = {5'($urandom_range(1, 30)), 10'($urandom)};
      return h;
   endfunction

   function automatic logic [LANES*DW-1:0] rand_lanes();
      logic [LANES*DW-1:0] r;
      for (int l = 0; l < LANES; l++) r[l*DW +: DW] = rand_fp16();
      return r;
   endfunction

   // output ready generator, changes just after the active edge
   initial begin
      forever begin
         @(posedge clk);
         #1;
         case (rdy_mode)
            0:       o_ready = 1'b1;
            1:       o_ready = ($urandom_range(0, 3) != 0);
            default: o_ready = 1'b0;
         endcase
      end
   end

   // result monitor / scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && o_valid) begin
            if (o_ready) begin
               if (exp_q.size() == 0) begin
                  check_eq("unexpected_result", o_valid, 0);
               end else begin
                  e = exp_q.pop_front();
                  n_results++;
                  $display("[%0t] result %0d acc=%h nan=%b inf=%b neg=%b ovf=%b", $time, n_results,
                           o_acc, o_nan, o_inf, o_inf_neg, o_ovf);
                  if (e.chk_acc) check_eq("acc", o_acc, e.acc);
                  check_eq("nan", o_nan, e.nan);
                  check_eq("inf", o_inf, e.inf);
                  check_eq("inf_neg", o_inf_neg, e.neg);
                  check_eq("ovf", o_ovf, e.ovf);
               end
            end else begin
               check_eq("bp_i_ready", i_ready, 0);
               if (exp_q.size() != 0 && exp_q[0].chk_acc) check_eq("bp_hold_acc", o_acc, exp_q[0].acc);
            end
         end
      end
   end

   initial begin
      logic [AW-1:0] init_v;
      logic [95:0]   r96;
      int            len;
      logic          grp_first;

      repeat (3) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state();

      // single beat 1.0 x 2.0 on four lanes, with latency check
      send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 1, 1, '0);
      @(negedge clk); check_eq("lat_e0", o_valid, 0);
      @(negedge clk); check_eq("lat_e1", o_valid, 0);
      @(negedge clk); check_eq("lat_e2", o_valid, 1);
      wait_drain();

      // three beat group with non-zero base
      send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 1, 0, AW'(1) << 48);
      send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 0, 0, AW'(12345));
      send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 0, 1, AW'(777));
      wait_drain();

      // smallest subnormal product, and max-magnitude cancellation
      send_beat(pack4(16'h0001, 0, 0, 0), pack4(16'h0001, 0, 0, 0), 1, 1, '0);
      send_beat(pack4(16'h7BFF, 16'hFBFF, 0, 0), pack4(16'h7BFF, 16'h7BFF, 0, 0), 1, 1, '0);
      wait_drain();

      // specials: inf x 0, -inf x 1, +inf with -inf
      send_beat(pack4(16'h7C00, 0, 0, 0), pack4(16'h0000, 0, 0, 0), 1, 1, '0);
      send_beat(pack4(16'hFC00, 0, 0, 0), pack4(16'h3C00, 0, 0, 0), 1, 1, '0);
      send_beat(pack4(16'h7C00, 16'hFC00, 0, 0), pack4(16'h3C00, 16'h3C00, 0, 0), 1, 1, '0);
      wait_drain();

      // signed overflow at the top of the range, then continuation without first
      send_beat(pack4(16'h0001, 0, 0, 0), pack4(16'h0001, 0, 0, 0), 1, 1, {1'b0, {(AW-1){1'b1}}});
      send_beat(pack4(16'h0001, 0, 0, 0), pack4(16'h0001, 0, 0, 0), 0, 1, '0);
      wait_drain();

      // backpressure: result held while a following group queues up
      rdy_mode = 2;
      repeat (2) @(negedge clk);
      send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                pack4(16'h4000, 16'h4000, 16'h4000, 16'h4000), 1, 1, '0);
      fork
         begin
            send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                      pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 1, 0, '0);
            send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                      pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 0, 0, '0);
            send_beat(pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00),
                      pack4(16'h3C00, 16'h3C00, 16'h3C00, 16'h3C00), 0, 1, '0);
         end
         begin
            repeat (8) @(negedge clk);
            rdy_mode = 0;
         end
      join
      wait_drain();

      // reset in the middle of a group
      send_beat(pack4(16'h4000, 16'h4000, 0, 0), pack4(16'h4000, 16'h4000, 0, 0), 1, 0, AW'(12345));
      send_beat(pack4(16'h4000, 16'h4000, 0, 0), pack4(16'h4000, 16'h4000, 0, 0), 0, 0, '0);
      @(negedge clk);
      rst_n = 1'b0;
      m_acc = '0; m_nan = 0; m_pinf = 0; m_ninf = 0; m_ovf = 0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check_reset_state();
      send_beat(pack4(16'h0001, 0, 0, 0), pack4(16'h0001, 0, 0, 0), 1, 1, '0);
      wait_drain();

      // randomized groups under random backpressure
      rdy_mode = 1;
      for (int g = 0; g < 40; g++) begin
         len       = $urandom_range(1, 4);
         grp_first = (g == 0) || ($urandom_range(0, 7) != 0);
         for (int k = 0; k < len; k++) begin
            r96 = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 1) == 1) init_v = r96[AW-1:0];
            else                           init_v = {{(AW-32){r96[31]}}, r96[31:0]};
            send_beat(rand_lanes(), rand_lanes(), grp_first && (k == 0), k == len - 1, init_v);
         end
      end
      rdy_mode = 0;
      wait_drain();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
